// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: FSM states, PC source encoding
// and the bundle of per-stage control strobes.
package cpu_types_pkg;

    typedef enum logic [1:0] {RUN, DWAIT, HALT} pipe_state_t;

    typedef enum logic [1:0] {PC_SEQ, PC_JUMP, PC_BRANCH} pc_sel_t;

    typedef struct packed {
        logic    pc_en;
        pc_sel_t pc_sel;
        logic    ifid_en;
        logic    idex_en;
        logic    exmem_en;
        logic    memwb_en;
        logic    ifid_flush;
        logic    idex_flush;
        logic    exmem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '{
        pc_en:       1'b0,
        pc_sel:      PC_SEQ,
        ifid_en:     1'b0,
        idex_en:     1'b0,
        exmem_en:    1'b0,
        memwb_en:    1'b0,
        ifid_flush:  1'b0,
        idex_flush:  1'b0,
        exmem_flush: 1'b0
    };

    // A load in ID/EX whose result the IF/ID instruction reads; r0 never conflicts.
    function automatic logic load_use(input logic       ld,
                                      input logic [4:0] dest,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
        return ld && (dest != 5'd0) && ((dest == rs) || (dest == rt));
    endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and a freeze input; it holds
// at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && !freeze && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline register sequencer: stage enables/flushes, PC source, halt, and
// saturating debug counters for stall cycles and control-flow flushes.
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_jump,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_dest,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_branch_taken,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_old_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t state, state_next;
    pipe_ctrl_t  ctrl;
    logic        dmem_req;
    logic        lu_hazard;
    logic        advance;
    logic        flush_evt;
    logic        stall_evt;
    logic        halted;

    assign dmem_req  = exmem_dREN | exmem_dWEN;
    assign lu_hazard = load_use(idex_dREN, idex_dest, ifid_rs, ifid_rt);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (dmem_req && !dhit) begin
                    state_next = DWAIT;
                end else if (exmem_halt && ctrl.memwb_en) begin
                    state_next = HALT;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    state_next = (exmem_halt && ctrl.memwb_en) ? HALT : RUN;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // The stages move only in RUN without a dcache miss, or on the dhit cycle of DWAIT.
    assign advance = ((state == RUN) && !(dmem_req && !dhit)) ||
                     ((state == DWAIT) && dhit);

    always_comb begin
        // NOTE: every field gets a default before the branches, so no path infers a latch.
        ctrl      = CTRL_IDLE;
        flush_evt = 1'b0;
        if (!RST && advance) begin
            if (exmem_branch_taken) begin
                ctrl.pc_en      = 1'b1;
                ctrl.pc_sel     = PC_BRANCH;
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
                flush_evt       = 1'b1;
            end else if (ifid_jump) begin
                ctrl.pc_en      = 1'b1;
                ctrl.pc_sel     = PC_JUMP;
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_en    = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
                flush_evt       = 1'b1;
            end else if (lu_hazard) begin
                ctrl.idex_flush = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
            end else if (!ihit) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_en    = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
            end else begin
                ctrl.pc_en    = 1'b1;
                ctrl.ifid_en  = 1'b1;
                ctrl.idex_en  = 1'b1;
                ctrl.exmem_en = 1'b1;
                ctrl.memwb_en = 1'b1;
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign pc_sel       = ctrl.pc_sel;
    assign ifid_en      = ctrl.ifid_en;
    assign idex_en      = ctrl.idex_en;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwb_old_en = ctrl.memwb_en;

    assign halted    = (state == HALT);
    assign halt      = halted;
    assign stall_evt = !ctrl.pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (stall_evt),
        .freeze (halted),
        .count  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (flush_evt),
        .freeze (halted),
        .count  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: stimulus table, directed
// multi-cycle sequences and a randomized run against a rule-level model.
module tb_pipeline_controller;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef enum int {M_RUN, M_WAIT, M_HALTED} mode_t;
    typedef enum int {A_OFF, A_BRANCH, A_JUMP, A_LOADUSE, A_IMISS, A_NORMAL} act_t;

    typedef struct {
        bit       rst;
        bit       ihit;
        bit       dhit;
        bit       jump;
        bit       ld;
        bit       dren;
        bit       dwen;
        bit       br;
        bit       hlt;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] dest;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [10:0] exp;
    } vec_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, ifid_jump, idex_dREN, exmem_dREN, exmem_dWEN;
    logic             exmem_branch_taken, exmem_halt;
    logic [4:0]       ifid_rs, ifid_rt, idex_dest;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_old_en, halt;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int    checks   = 0;
    int    failures = 0;
    mode_t mode     = M_RUN;
    int    exp_stall = 0;
    int    exp_flush = 0;
    vec_t  tbl[$];

    pipeline_controller #(.CNT_W(CNT_W)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .ihit               (ihit),
        .dhit               (dhit),
        .ifid_rs            (ifid_rs),
        .ifid_rt            (ifid_rt),
        .ifid_jump          (ifid_jump),
        .idex_dREN          (idex_dREN),
        .idex_dest          (idex_dest),
        .exmem_dREN         (exmem_dREN),
        .exmem_dWEN         (exmem_dWEN),
        .exmem_branch_taken (exmem_branch_taken),
        .exmem_halt         (exmem_halt),
        .pc_en              (pc_en),
        .pc_sel             (pc_sel),
        .ifid_en            (ifid_en),
        .idex_en            (idex_en),
        .exmem_en           (exmem_en),
        .memwb_en           (memwb_en),
        .ifid_flush         (ifid_flush),
        .idex_flush         (idex_flush),
        .exmem_flush        (exmem_flush),
        .memwb_old_en       (memwb_old_en),
        .halt               (halt),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.ihit = 1; s.dhit = 1; s.jump = 0; s.ld = 0; s.dren = 0;
        s.dwen = 0; s.br = 0; s.hlt = 0; s.rs = 0; s.rt = 0; s.dest = 0;
        return s;
    endfunction

    // Which priority rule the controller should apply this cycle.
    function automatic act_t model_act(input mode_t m, input stim_t s);
        bit hz;
        if (s.rst || m == M_HALTED) return A_OFF;
        if (m == M_RUN && (s.dren || s.dwen) && !s.dhit) return A_OFF;
        if (m == M_WAIT && !s.dhit) return A_OFF;
        hz = s.ld && (s.dest != 0) && (s.dest == s.rs || s.dest == s.rt);
        if (s.br)    return A_BRANCH;
        if (s.jump)  return A_JUMP;
        if (hz)      return A_LOADUSE;
        if (!s.ihit) return A_IMISS;
        return A_NORMAL;
    endfunction

    // {pc_en, pc_sel, ifid/idex/exmem/memwb_en, ifid/idex/exmem_flush, memwb_old_en}
    function automatic logic [10:0] act_outputs(input act_t a);
        case (a)
            A_BRANCH:  return 11'b1_10_0011_110_1;
            A_JUMP:    return 11'b1_01_0111_100_1;
            A_LOADUSE: return 11'b0_00_0011_010_1;
            A_IMISS:   return 11'b0_00_0111_100_1;
            A_NORMAL:  return 11'b1_00_1111_000_1;
            default:   return 11'b0;
        endcase
    endfunction

    task automatic drive(input stim_t s);
        RST = s.rst; ihit = s.ihit; dhit = s.dhit; ifid_jump = s.jump;
        idex_dREN = s.ld; exmem_dREN = s.dren; exmem_dWEN = s.dwen;
        exmem_branch_taken = s.br; exmem_halt = s.hlt;
        ifid_rs = s.rs; ifid_rt = s.rt; idex_dest = s.dest;
    endtask

    task automatic step(input stim_t s, input bit use_tbl = 1'b0,
                        input logic [10:0] tbl_exp = '0, input string tname = "");
        act_t        a;
        logic [10:0] exp_o;
        logic [10:0] got;
        drive(s);
        @(negedge CLK);
        a     = model_act(mode, s);
        exp_o = act_outputs(a);
        got   = {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_old_en};
        check("ctrl_vs_model", {21'b0, got}, {21'b0, exp_o});
        if (use_tbl) check(tname, {21'b0, got}, {21'b0, tbl_exp});
        check("halt", {31'b0, halt}, {31'b0, mode == M_HALTED});
        check("stall_cnt", {28'b0, stall_cnt}, exp_stall);
        check("flush_cnt", {28'b0, flush_cnt}, exp_flush);
        @(posedge CLK);
        if (s.rst) begin
            mode = M_RUN; exp_stall = 0; exp_flush = 0;
        end else if (mode != M_HALTED) begin
            if (!exp_o[10]) exp_stall = (exp_stall < CNT_MAX) ? exp_stall + 1 : CNT_MAX;
            if (a == A_BRANCH || a == A_JUMP)
                exp_flush = (exp_flush < CNT_MAX) ? exp_flush + 1 : CNT_MAX;
            if (mode == M_RUN && (s.dren || s.dwen) && !s.dhit) mode = M_WAIT;
            else if (a != A_OFF && s.hlt)                       mode = M_HALTED;
            else if (mode == M_WAIT && s.dhit)                  mode = M_RUN;
        end
        #1;
    endtask

    task automatic add(input string name, input stim_t s, input logic [10:0] exp);
        vec_t v;
        v.name = name; v.s = s; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t s, r;
        r = idle(); r.rst = 1;
        drive(r);
        repeat (2) @(posedge CLK);
        #1;
        step(r);

        s = idle();                                         add("normal",     s, 11'b1_00_1111_000_1);
        s = idle(); s.ld = 1; s.dest = 5; s.rs = 5;         add("lu_rs",      s, 11'b0_00_0011_010_1);
        s = idle(); s.ld = 1; s.dest = 7; s.rt = 7;         add("lu_rt",      s, 11'b0_00_0011_010_1);
        s = idle(); s.ld = 1; s.dest = 0;                   add("lu_r0",      s, 11'b1_00_1111_000_1);
        s = idle(); s.ihit = 0;                             add("imiss",      s, 11'b0_00_0111_100_1);
        s = idle(); s.jump = 1;                             add("jump",       s, 11'b1_01_0111_100_1);
        s = idle(); s.jump = 1; s.ihit = 0;                 add("jump_imiss", s, 11'b1_01_0111_100_1);
        s = idle(); s.br = 1;                               add("branch",     s, 11'b1_10_0011_110_1);
        s = idle(); s.br = 1; s.ld = 1; s.dest = 3; s.rs = 3; add("branch_lu", s, 11'b1_10_0011_110_1);
        s = idle(); s.br = 1; s.ihit = 0;                   add("branch_imiss", s, 11'b1_10_0011_110_1);
        s = idle(); s.dwen = 1; s.dhit = 0;                 add("dmiss",      s, 11'b0);
        s = idle(); s.dren = 1; s.dhit = 0; s.ihit = 0;     add("dmiss_imiss", s, 11'b0);
        s = idle(); s.dren = 1;                             add("dhit",       s, 11'b1_00_1111_000_1);
        s = idle(); s.rst = 1; s.br = 1;                    add("in_reset",   s, 11'b0);
        foreach (tbl[i]) begin
            step(r);
            step(tbl[i].s, 1'b1, tbl[i].exp, tbl[i].name);
        end

        // Load-use stalls exactly one cycle.
        step(r);
        s = idle(); s.ld = 1; s.dest = 5; s.rs = 5; step(s);
        step(idle());
        check("lu_stall_cnt", {28'b0, stall_cnt}, 1);

        // Store waits three cycles for the dcache, then advances.
        step(r);
        s = idle(); s.dwen = 1; s.dhit = 0;
        repeat (3) step(s);
        s.dhit = 1; step(s, 1'b1, 11'b1_00_1111_000_1, "dwait_release");
        step(idle(), 1'b1, 11'b1_00_1111_000_1, "after_dwait");
        check("dwait_stall_cnt", {28'b0, stall_cnt}, 3);

        // Branch wait: jump pending while the dcache misses is acted on once at dhit.
        step(r);
        s = idle(); s.dren = 1; s.dhit = 0; s.jump = 1;
        repeat (2) step(s);
        s.dhit = 1; s.dren = 0; step(s, 1'b1, 11'b1_01_0111_100_1, "jump_at_dhit");
        check("jump_wait_flush_cnt", {28'b0, flush_cnt}, 1);

        // Branch plus load-use: branch wins, no stall.
        step(r);
        s = idle(); s.br = 1; s.ld = 1; s.dest = 9; s.rt = 9; step(s);
        check("br_lu_flush_cnt", {28'b0, flush_cnt}, 1);
        check("br_lu_stall_cnt", {28'b0, stall_cnt}, 0);

        // Halt freezes everything until reset.
        step(r);
        s = idle(); s.jump = 1; step(s);
        s = idle(); s.ihit = 0; step(s);
        s = idle(); s.hlt = 1;  step(s);
        check("halt_set", {31'b0, halt}, 1);
        s = idle(); s.ihit = 0; s.br = 1;
        repeat (10) step(s, 1'b1, 11'b0, "halted_idle");
        check("halt_stall_frozen", {28'b0, stall_cnt}, 1);
        check("halt_flush_frozen", {28'b0, flush_cnt}, 1);
        step(r);
        check("halt_cleared", {31'b0, halt}, 0);
        check("reset_stall", {28'b0, stall_cnt}, 0);
        check("reset_flush", {28'b0, flush_cnt}, 0);
        step(idle(), 1'b1, 11'b1_00_1111_000_1, "run_after_halt");

        // Stall counter saturation.
        step(r);
        s = idle(); s.ihit = 0;
        repeat (CNT_MAX + 6) step(s);
        check("stall_saturate", {28'b0, stall_cnt}, CNT_MAX);

        // Randomized run against the rule-level model.
        step(r);
        for (int n = 0; n < 3000; n++) begin
            s.rst  = ($urandom_range(0, 99) < 2);
            s.ihit = ($urandom_range(0, 99) < 80);
            s.dhit = ($urandom_range(0, 99) < 60);
            s.jump = ($urandom_range(0, 99) < 12);
            s.ld   = ($urandom_range(0, 99) < 40);
            s.dren = ($urandom_range(0, 99) < 20);
            s.dwen = ($urandom_range(0, 99) < 15);
            s.br   = ($urandom_range(0, 99) < 12);
            s.hlt  = ($urandom_range(0, 99) < 2);
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.dest = 5'($urandom_range(0, 3));
            step(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Produces per-stage enable and flush, the PC source select, and the capture enable for the held MEM/WB copy that the forwarding logic reads.
- Resolves icache/dcache wait, load-use stall, jump and branch flush, and halt.
- Keeps saturating stall and flush counters for debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ihit  in  1  icache returns the instruction this cycle
dhit  in  1  dcache completes the EX/MEM access this cycle
ifid_rs  in  5  rs field of the instruction in IF/ID
ifid_rt  in  5  rt field of the instruction in IF/ID
ifid_jump  in  1  J/JAL/JR decoded in ID
idex_dREN  in  1  instruction in ID/EX is a load
idex_dest  in  5  destination register of ID/EX
exmem_dREN  in  1  EX/MEM load
exmem_dWEN  in  1  EX/MEM store
exmem_branch_taken  in  1  branch in EX/MEM resolved taken
exmem_halt  in  1  HALT in EX/MEM
pc_en  out  1  PC update
pc_sel  out  2  0=PC+4, 1=jump target, 2=branch target
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0)
memwb_old_en  out  1  capture the current MEM/WB contents into the held copy
halt  out  1  sticky halted flag
stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
flush_cnt  out  CNT_W  jump plus branch flush events

Behaviour:
- Definitions:
  - dmem_req = exmem_dREN | exmem_dWEN.
  - lu_hazard = idex_dREN & idex_dest!=0 & (idex_dest==ifid_rs | idex_dest==ifid_rt).
- FSM states: RUN, DWAIT, HALT. Reset enters RUN. All outputs are combinational from state and inputs, except halt and the counters, which are registered.
- Reset (RST=1 at an edge):
  - State becomes RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - All enables and flushes are 0 while RST is high.
  - Reset mid-DWAIT or in HALT returns to RUN on the same edge.
- Outputs in RUN, priority highest first:
  1. dmem_req & !dhit: all enables=0, pc_en=0, no flush; next state DWAIT.
  2. exmem_branch_taken: pc_sel=2, pc_en=1; ifid_flush=1, idex_flush=1; exmem_en=1, memwb_en=1; flush_cnt+1.
  3. ifid_jump: pc_sel=1, pc_en=1, ifid_flush=1; other stages enabled; flush_cnt+1.
  4. lu_hazard: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. The bubble clears the hazard, so the stall lasts exactly 1 cycle.
  5. !ihit: pc_en=0, ifid_flush=1, downstream stages enabled.
  6. Otherwise: all enables=1, pc_sel=0.
- Flush dominates enable on the same register.
- memwb_old_en = memwb_en in every state.
- DWAIT:
  - Everything frozen while dhit=0.
  - On the cycle dhit=1: evaluate the RUN priority list with rule 1 removed; next state RUN.
  - A branch, jump or load-use pending in the frozen stages is therefore acted on exactly once, on the dhit cycle.
- HALT:
  - Entered on an edge where exmem_halt=1 and memwb_en=1.
  - halt=1; all enables and flushes 0, pc_en=0; counters frozen.
  - Left only by reset.
- Counters:
  - stall_cnt increments on each non-HALT cycle with pc_en=0.
  - flush_cnt increments per flush event.
  - Both saturate at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - Branch with !ihit: the branch wins, pc_en=1.
  - Branch with load-use: the branch wins; the load-use consumer is flushed.
  - dhit and ihit both low in RUN: the dcache wait wins.

Decomposition:
- Shared package cpu_types_pkg gets:
  - typedef enum logic [1:0] {RUN, DWAIT, HALT} pipe_state_t.
  - typedef enum logic [1:0] {PC_SEQ, PC_JUMP, PC_BRANCH} pc_sel_t.
- One sub-module: sat_counter (parameter W; inputs CLK, RST, inc, freeze; output count), instantiated twice.

Test Plan:
- Reset, then ihit=1 with no hazards → all enables=1, pc_sel=0, stall_cnt=0, halt=0.
- Load-use: idex_dREN=1, idex_dest=5, ifid_rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle (idex_dREN=0) all enables=1; stall_cnt=1.
- exmem_dWEN=1 with dhit=0 for 3 cycles, then 1 → 3 frozen cycles in DWAIT, advance on cycle 4, back to RUN; stall_cnt=3.
- exmem_branch_taken=1 and lu_hazard in the same cycle → pc_sel=2, ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1; no stall.
- exmem_halt=1 → halt=1 next cycle, all enables 0 for 10 cycles, counters unchanged; RST=1 → state RUN, halt=0, counters 0.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) → stall_cnt holds 15.
